io_bus_master: RTL and testbench
================================

# io_bus_master

CPU-side initiator for the memory-mapped I/O controller bus. It accepts byte, half-word and word load/store requests from the core, then drives the controller's word-wide strobe interface (ADDR, DIN, WE, RREQ) and waits for RDY. It sign- or zero-extends load data and performs read-modify-write for sub-word stores. Bus hangs are bounded by a timeout, and every request completes with exactly one response pulse.

## Interface
- TIMEOUT, 255: max cycles a bus strobe is held without RDY before abort (1..65535)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ  in  1  request strobe; accepted on a rising edge when BUSY=0
- REQ_WE  in  1  1=store, 0=load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- REQ_UNS  in  1  load zero-extends when 1, sign-extends when 0
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, right-aligned
- BUSY  out  1  request in flight; REQ ignored while high
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_RDATA  out  32  extended load data; 0 for stores and errors
- RESP_ERR  out  1  misaligned, illegal size or timeout; qualified by RESP_VALID
- ADDR  out  32  word address to controller, bits [1:0] always 0
- DIN  out  32  write data to controller
- WE  out  1  write strobe
- RREQ  out  1  read strobe
- DO  in  32  read data from controller, valid when RDY=1 during RREQ
- RDY  in  1  controller completion, sampled only while WE or RREQ is high

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE. BUSY = (state != IDLE).
- IDLE + REQ: capture all REQ_* fields.
  - Illegal size, half with addr[0]=1, or word with addr[1:0]!=0: go to DONE with error. No bus activity.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte or half store: go to RMW_RD.
- RD / RMW_RD: RREQ=1, ADDR={addr[31:2],2'b00}.
  - On RD with RDY: lane = DO >> (8*addr[1:0]). Truncate to 8/16/32 bits, then extend per REQ_UNS. Go to DONE.
  - On RMW_RD with RDY: latch DO, then go to RMW_WR.
- RMW_WR: DIN = latched word with the addressed byte/half lane replaced by REQ_WDATA[7:0]/[15:0]. Other lanes are unchanged. WE=1 until RDY, then go to DONE.
- WR: DIN=REQ_WDATA, WE=1 until RDY, then go to DONE.
- Timeout: a per-phase counter clears on entry to each RD/WR/RMW_* state.
  - If it reaches TIMEOUT with no RDY, drop the strobe and go to DONE with error.
  - A timeout in RMW_RD skips the write entirely.
- DONE: RESP_VALID=1 for one cycle with RESP_RDATA/RESP_ERR, then go to IDLE.
- WE and RREQ are never high together. Both are decoded from registered state (glitch-free). ADDR/DIN stay stable for the whole strobe.
- RDY while no strobe is active is ignored.

## Timing
- Reset values: all outputs 0. State is IDLE, counter is 0.
- RST asserted mid-transaction: strobes drop immediately (asynchronous). No RESP_VALID for the aborted request.
- Edge E0 accepts the request. BUSY and strobe are high from E0.
- RDY sampled high at edge E1 → RESP_VALID is high in the cycle after E1.
- Minimum latency, accept to RESP_VALID:
  - plain load/store: 2 cycles
  - RMW: 3 cycles (RREQ→WE switch with no gap cycle)
  - error detected at accept: 1 cycle
- A timeout holds the strobe for exactly TIMEOUT cycles.
- BUSY falls at the edge that ends the DONE cycle. REQ is accepted at the next edge, so back-to-back throughput is one request per (latency+1) cycles.
- REQ asserted while BUSY=1 is dropped. It is not queued.

## Test plan
- Word load, addr 0x100, DO=0x8000_00F0, RDY after 3 cycles → RREQ high 3 cycles, ADDR=0x100, RESP_RDATA=0x8000_00F0, ERR=0.
- Byte loads at 0x103 with DO=0x80AB_CDEF → signed: RESP_RDATA=0xFFFF_FF80. Unsigned: RESP_RDATA=0x0000_0080.
- Half store 0xBEEF at 0x202, controller word 0x1122_3344, RDY immediate → RREQ one cycle, then WE one cycle with DIN=0xBEEF_3344, ADDR=0x200, RESP_VALID 3 cycles after accept.
- Word store at 0x005 → no strobe, RESP_VALID next cycle with ERR=1. REQ_SIZE=11 gives the same result.
- TIMEOUT=4, load with RDY never high → RREQ high exactly 4 cycles, then RESP_VALID with ERR=1, RDATA=0. Next REQ is accepted normally.
- RST pulsed while WE high during RMW_WR → WE=0 and BUSY=0 immediately, no RESP_VALID. A following word load completes normally.

Source files
------------

// File: rtl/io_bus_master_if.sv
// rtl/io_bus_master_if.sv - core request/response and I/O controller strobe bundle
//
// Purpose: bundles the core-side request/response handshake with the
// word-wide strobe bus of the memory-mapped I/O controller.
// Port summary (master view):
//   in  req, req_we, req_size[1:0], req_uns, req_addr[31:0], req_wdata[31:0]
//   out busy, resp_valid, resp_rdata[31:0], resp_err
//   out addr[31:0], din[31:0], we, rreq
//   in  dout[31:0] (controller read data), rdy
interface io_bus_master_if;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic        rreq;
    logic [31:0] dout;
    logic        rdy;

    modport master (
        input  req, req_we, req_size, req_uns, req_addr, req_wdata,
        input  dout, rdy,
        output busy, resp_valid, resp_rdata, resp_err,
        output addr, din, we, rreq
    );

    modport slave (
        output req, req_we, req_size, req_uns, req_addr, req_wdata,
        output dout, rdy,
        input  busy, resp_valid, resp_rdata, resp_err,
        input  addr, din, we, rreq
    );
endinterface

// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU-side load/store initiator for the I/O controller strobe bus
//
// Purpose: accepts byte/half/word loads and stores, drives the controller's
// ADDR/DIN/WE/RREQ strobes until RDY, extends load data, performs
// read-modify-write for sub-word stores and aborts hung strobes after
// TIMEOUT cycles. Every accepted request yields exactly one resp_valid pulse.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-high reset
//   bus    io_bus_master_if.master (request, response and strobe signals)
// Parameter:
//   TIMEOUT  cycles a strobe is held without rdy before abort (1..65535)
module io_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    io_bus_master_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] din_q, din_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        rreq_q, rreq_d;
    logic        we_q, we_d;

    logic [4:0]  lane_shamt;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        timeout;
    logic        bad_req;

    // Lane selection and sign/zero extension of the returned controller word.
    always_comb begin
        lane_shamt = {addr_q[1:0], 3'b000};
        lane       = bus.dout >> lane_shamt;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Sub-word store merge: only the addressed byte/half lane is replaced.
    always_comb begin
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shamt;
        merged    = (bus.dout & ~lane_mask) | ((wdata_q << lane_shamt) & lane_mask);
    end

    always_comb begin
        bad_req = (bus.req_size == 2'b11)
               || ((bus.req_size == 2'b01) && bus.req_addr[0])
               || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        cnt_d   = cnt_q + 16'd1;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (bus.req) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_uns;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (bad_req) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (!bus.req_we) begin
                        state_d = S_RD;
                    end else if (bus.req_size == 2'b10) begin
                        din_d   = bus.req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                // rdy wins over the timeout on the final allowed cycle.
                if (bus.rdy) begin
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RMW_RD: begin
                if (bus.rdy) begin
                    din_d   = merged;
                    cnt_d   = 16'd0;
                    state_d = S_RMW_WR;
                end else if (timeout) begin
                    // Abandon the store: the write phase never starts.
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR, S_RMW_WR: begin
                if (bus.rdy) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = 16'd0;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they come straight
        // off flops and can never overlap.
        rreq_d = (state_d == S_RD) || (state_d == S_RMW_RD);
        we_d   = (state_d == S_WR) || (state_d == S_RMW_WR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            din_q   <= 32'h0;
            cnt_q   <= 16'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            rreq_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rreq_q  <= rreq_d;
            we_q    <= we_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = (state_q == S_DONE);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.addr       = {addr_q[31:2], 2'b00};
    assign bus.din        = din_q;
    assign bus.rreq       = rreq_q;
    assign bus.we         = we_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - scoreboard testbench for io_bus_master
module tb_io_bus_master;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_bus_master_if bus();

    io_bus_master #(.TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response per resp_valid pulse.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, mon_e.rdata);
                check("resp_err", {31'h0, bus.resp_err}, {31'h0, mon_e.err});
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_uns   = uns;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    // Controller model: answers each strobe phase with rdy on its delay-th
    // cycle (delay 0 = never) and records what the master drove.
    task automatic run_bus(input int delay, input logic [31:0] word,
                           output int rd_cyc, output int wr_cyc, output int lat,
                           output logic [31:0] s_addr, output logic [31:0] s_din);
        int   ph;
        logic last_we;
        logic done;
        rd_cyc = 0; wr_cyc = 0; lat = 0; s_addr = 32'h0; s_din = 32'h0;
        ph = 0; last_we = 1'b0; done = 1'b0;
        for (int idx = 1; idx <= 40 && !done; idx++) begin
            if (!bus.busy) begin
                done = 1'b1;
            end else begin
                if (bus.rreq && bus.we) check("strobe_overlap", 32'd1, 32'd0);
                if (bus.resp_valid && lat == 0) lat = idx;
                if (bus.rreq || bus.we) begin
                    if (bus.we != last_we) ph = 0;
                    last_we = bus.we;
                    ph++;
                    if (bus.rreq) rd_cyc++; else wr_cyc++;
                    s_addr = bus.addr;
                    if (bus.we) s_din = bus.din;
                    bus.rdy  = (delay != 0) && (ph == delay);
                    bus.dout = word;
                end else begin
                    bus.rdy = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.rdy = 1'b0;
        if (!done) check("busy_bound_expired", 32'd1, 32'd0);
    endtask

    task automatic txn(input string nm, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int delay,
                       input logic [31:0] word, input logic [31:0] e_rdata, input logic e_err,
                       input int e_rd, input int e_wr, input int e_lat,
                       input logic [31:0] e_addr, input logic [31:0] e_din);
        int rd_c, wr_c, lat;
        logic [31:0] s_addr, s_din;
        resp_t e;
        e.rdata = e_rdata;
        e.err   = e_err;
        exp_q.push_back(e);
        do_req(we, size, uns, a, wd);
        run_bus(delay, word, rd_c, wr_c, lat, s_addr, s_din);
        check({nm, "_rreq_cycles"}, rd_c, e_rd);
        check({nm, "_we_cycles"}, wr_c, e_wr);
        check({nm, "_latency"}, lat, e_lat);
        if (e_rd + e_wr > 0) check({nm, "_addr"}, s_addr, e_addr);
        if (e_wr > 0) check({nm, "_din"}, s_din, e_din);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_uns = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.dout = 32'h0; bus.rdy = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("reset_resp_rdata", bus.resp_rdata, 32'h0);
        check("reset_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("reset_addr", bus.addr, 32'h0);
        check("reset_din", bus.din, 32'h0);
        check("reset_strobes", {30'h0, bus.we, bus.rreq}, 32'h0);
        rst = 1'b0;

        // Stray rdy with no strobe must not start anything.
        bus.rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("stray_rdy_busy", {31'h0, bus.busy}, 32'h0);
        bus.rdy = 1'b0;

        //   name        we    size   uns  addr          wdata          dly word           rdata          err rd wr lat addr          din
        txn("ld_word",   1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        3, 32'h8000_00F0, 32'h8000_00F0, 1'b0, 3, 0, 4, 32'h0000_0100, 32'h0);
        txn("ld_b_sgn",  1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        1, 32'h80AB_CDEF, 32'hFFFF_FF80, 1'b0, 1, 0, 2, 32'h0000_0100, 32'h0);
        txn("ld_b_uns",  1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        1, 32'h80AB_CDEF, 32'h0000_0080, 1'b0, 1, 0, 2, 32'h0000_0100, 32'h0);
        txn("ld_b1_uns", 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        1, 32'h80AB_CDEF, 32'h0000_00CD, 1'b0, 1, 0, 2, 32'h0000_0100, 32'h0);
        txn("ld_h_sgn",  1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        2, 32'h80AB_CDEF, 32'hFFFF_80AB, 1'b0, 2, 0, 3, 32'h0000_0000, 32'h0);
        txn("ld_h_uns",  1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,        1, 32'h80AB_CDEF, 32'h0000_CDEF, 1'b0, 1, 0, 2, 32'h0000_0000, 32'h0);
        txn("st_half",   1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 1, 32'h1122_3344, 32'h0,        1'b0, 1, 1, 3, 32'h0000_0200, 32'hBEEF_3344);
        txn("st_byte",   1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_77A5, 1, 32'h1122_3344, 32'h0,        1'b0, 1, 1, 3, 32'h0000_0300, 32'h1122_A544);
        txn("st_word",   1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 2, 32'h0,         32'h0,        1'b0, 0, 2, 3, 32'h0000_0400, 32'hCAFE_F00D);
        txn("st_w_mis",  1'b1, 2'b10, 1'b0, 32'h0000_0005, 32'h1234_5678, 1, 32'h0,         32'h0,        1'b1, 0, 0, 1, 32'h0,         32'h0);
        txn("ill_size",  1'b1, 2'b11, 1'b0, 32'h0000_0005, 32'h1234_5678, 1, 32'h0,         32'h0,        1'b1, 0, 0, 1, 32'h0,         32'h0);
        txn("ld_h_mis",  1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        1, 32'hFFFF_FFFF, 32'h0,        1'b1, 0, 0, 1, 32'h0,         32'h0);
        txn("ld_tmo",    1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0,        0, 32'hFFFF_FFFF, 32'h0,        1'b1, 4, 0, 5, 32'h0000_0500, 32'h0);
        txn("rmw_tmo",   1'b1, 2'b00, 1'b0, 32'h0000_0602, 32'h0000_0055, 0, 32'hFFFF_FFFF, 32'h0,        1'b1, 4, 0, 5, 32'h0000_0600, 32'h0);
        txn("ld_rdy_lst",1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0,        4, 32'h1234_5678, 32'h1234_5678, 1'b0, 4, 0, 5, 32'h0000_0700, 32'h0);

        // Reset during the write phase of a read-modify-write.
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234);
        check("rst_rmw_rreq", {31'h0, bus.rreq}, 32'h1);
        bus.rdy  = 1'b1;
        bus.dout = 32'h1122_3344;
        @(negedge clk);
        bus.rdy = 1'b0;
        check("rst_rmw_we_before", {31'h0, bus.we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_we_drop", {31'h0, bus.we}, 32'h0);
        check("rst_busy_drop", {31'h0, bus.busy}, 32'h0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_idle_after", {31'h0, bus.busy}, 32'h0);

        txn("ld_post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 1, 0, 2, 32'h0000_0800, 32'h0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
